reg_wb_ctrl: RTL and testbench
==============================

Name: reg_wb_ctrl

Overview:
- Write-back and hazard controller that drives the 8x8 register array's write controls (LR0/LRN, S8 source select, RN_Reg_Sel) and owns the array's shared RN selector.
- Accepts write requests from issue, carries them through a DEPTH-stage in-flight pipeline, then fires them in a WB stage.
- Stalls issue on RAW hazards against in-flight writes, and on RN_Reg_Sel conflicts with the WB stage.

Parameters:
- DEPTH, 2, in-flight stages between issue and WB (legal 1..4).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  issue slot holds an instruction.
- id_rn_sel  in  3  RN index read and/or written by the instruction.
- id_uses_r0  in  1  instruction reads R0.
- id_uses_rn  in  1  instruction reads RN.
- id_wr_r0  in  1  instruction writes R0.
- id_wr_rn  in  1  instruction writes RN.
- id_src  in  3  write source code: 001 ALU, 010 OR2, 011 SP, 100 DM, 101 R0, 110 RN.
- flush  in  1  kill all in-flight (non-WB) writes.
- id_stall  out  1  issue must hold; the instruction is not accepted.
- ra_ctrl  out  2  array Control_in; [1] LRN, [0] LR0.
- ra_s8  out  3  array S8 source select.
- ra_rn_sel  out  3  array RN_Reg_Sel.
- busy  out  1  any in-flight or WB stage valid.
- stall_cnt  out  8  saturating count of stall cycles.

Behaviour:
- Reset (async, rst_n=0): all stage valids cleared; stall_cnt=0; ra_ctrl=00; ra_s8=000; busy=0; ra_rn_sel follows its combinational rule, giving id_rn_sel.
- Accept: id_valid & ~id_stall & ~flush & (id_wr_r0 | id_wr_rn). The request is captured into stage 1 at the edge. Non-writing instructions never enter the pipeline.
- Stages shift every cycle and never stall. Bubbles enter when nothing is accepted.
- Timing: a request presented in cycle 0 is in stage d during cycle d and in WB during cycle DEPTH+1. The array updates at the end of cycle DEPTH+1.
- ra_ctrl and ra_s8 are the WB register contents, or 00/000 when WB is invalid. ra_ctrl is asserted for exactly one cycle per request.
- Destination mask:
  - wr_r0 only: bit 0.
  - wr_rn only: bit rn_sel.
  - both (broadcast): 8'hFF.
- pend = OR of the masks of all valid stages, WB included.
- wb_needs_rn = WB valid & (wr_rn | src==110).
- ra_rn_sel = WB rn_sel if wb_needs_rn, else id_rn_sel.
- id_stall = id_valid & (A | B | C):
  - A: id_uses_r0 & pend[0].
  - B: id_uses_rn & pend[id_rn_sel].
  - C: id_uses_rn & wb_needs_rn & (WB rn_sel != id_rn_sel).
- id_stall is combinational and is 0 when id_valid=0.
- Write-after-write needs no stall; in-order completion guarantees it.
- An R0/RN source is read at WB time, so it sees all older writes.
- flush: stages 1..DEPTH are cleared at the edge. A request already in WB still completes. A request presented with flush in the same cycle is discarded.
- stall_cnt: increments on each cycle with id_stall=1 and saturates at 255.
- busy = OR of all stage valids, including WB.
- Reset mid-operation: in-flight writes are lost. ra_ctrl drops to 00 immediately, without waiting for a clock.

Test Plan:
- DEPTH=2; cycle 0: wr_rn, rn_sel=3, src=001. Required: cycle 3 shows ra_ctrl=10, ra_s8=001, ra_rn_sel=3; ra_ctrl=00 in all other cycles; busy=1 in cycles 1-3.
- RAW: cycle 0 write R3; cycle 1 read R3 (uses_rn, sel=3) held. Required: id_stall=1 in cycles 1-3, accepted in cycle 4, stall_cnt=3.
- Structural: WB writes R5 in cycle 3 while issue reads R2 (not pending). Required: id_stall=1 and ra_rn_sel=5 in cycle 3; cycle 4 gives id_stall=0 and ra_rn_sel=2.
- Broadcast: wr_r0 & wr_rn, src=100, at cycle 0. Required: any R0/RN read stalls in cycles 1-3; cycle 3 shows ra_ctrl=11, ra_s8=100.
- Flush: write issued in cycle 0, flush=1 in cycle 1. Required: no ra_ctrl pulse, busy=0 from cycle 2, no stall on that register.
- Reset: rst_n=0 mid-cycle 3 of test 1, before that cycle's edge. Required: ra_ctrl=00 immediately, stall_cnt=0, busy=0; after release, a new request completes normally.

Source files
------------

// File: rtl/reg_wb_ctrl.sv
// Write-back and hazard controller for the 8x8 register array.
// Carries write requests through DEPTH in-flight stages into a WB stage and stalls issue on hazards.
`timescale 1ns/1ps

module reg_wb_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [2:0] id_rn_sel,
    input  logic       id_uses_r0,
    input  logic       id_uses_rn,
    input  logic       id_wr_r0,
    input  logic       id_wr_rn,
    input  logic [2:0] id_src,
    input  logic       flush,
    output logic       id_stall,
    output logic [1:0] ra_ctrl,
    output logic [2:0] ra_s8,
    output logic [2:0] ra_rn_sel,
    output logic       busy,
    output logic [7:0] stall_cnt
);

    localparam int         WB     = DEPTH + 1;
    localparam logic [2:0] SRC_RN = 3'b110;

    // Index WB holds the write-back stage; 1..DEPTH are the in-flight stages.
    logic [WB:1] st_valid;
    logic [WB:1] st_wr_r0;
    logic [WB:1] st_wr_rn;
    logic [2:0]  st_sel [1:WB];
    logic [2:0]  st_src [1:WB];

    logic       accept;
    logic [7:0] pend;
    logic       wb_needs_rn;
    logic       haz_r0;
    logic       haz_rn;
    logic       haz_sel;

    function automatic logic [7:0] dest_mask(input logic       v,
                                             input logic       wr_r0,
                                             input logic       wr_rn,
                                             input logic [2:0] sel);
        logic [7:0] m;
        m = 8'h00;
        if (v) begin
            if (wr_r0 && wr_rn)
                m = 8'hFF;
            else if (wr_r0)
                m = 8'h01;
            else if (wr_rn)
                m = 8'(1) << sel;
        end
        return m;
    endfunction

    assign accept = id_valid & ~id_stall & ~flush & (id_wr_r0 | id_wr_rn);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid <= '0;
            st_wr_r0 <= '0;
            st_wr_rn <= '0;
            for (int i = 1; i <= WB; i++) begin
                st_sel[i] <= 3'd0;
                st_src[i] <= 3'd0;
            end
        end else begin
            st_valid[1] <= accept;
            st_wr_r0[1] <= id_wr_r0;
            st_wr_rn[1] <= id_wr_rn;
            st_sel[1]   <= id_rn_sel;
            st_src[1]   <= id_src;
            // A flush kills stage DEPTH too, so nothing advances into WB on that edge.
            for (int i = 2; i <= WB; i++) begin
                st_valid[i] <= st_valid[i-1] & ~flush;
                st_wr_r0[i] <= st_wr_r0[i-1];
                st_wr_rn[i] <= st_wr_rn[i-1];
                st_sel[i]   <= st_sel[i-1];
                st_src[i]   <= st_src[i-1];
            end
        end
    end

    always_comb begin
        pend = 8'h00;
        for (int i = 1; i <= WB; i++)
            pend = pend | dest_mask(st_valid[i], st_wr_r0[i], st_wr_rn[i], st_sel[i]);
    end

    assign wb_needs_rn = st_valid[WB] & (st_wr_rn[WB] | (st_src[WB] == SRC_RN));
    assign ra_rn_sel   = wb_needs_rn ? st_sel[WB] : id_rn_sel;

    assign haz_r0   = id_uses_r0 & pend[0];
    assign haz_rn   = id_uses_rn & pend[id_rn_sel];
    // The array has a single RN selector, so WB owning it blocks any other RN read.
    assign haz_sel  = id_uses_rn & wb_needs_rn & (st_sel[WB] != id_rn_sel);
    assign id_stall = id_valid & (haz_r0 | haz_rn | haz_sel);

    assign ra_ctrl = st_valid[WB] ? {st_wr_rn[WB], st_wr_r0[WB]} : 2'b00;
    assign ra_s8   = st_valid[WB] ? st_src[WB] : 3'b000;
    assign busy    = |st_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= 8'd0;
        else if (id_stall && (stall_cnt != 8'hFF))
            stall_cnt <= stall_cnt + 8'd1;
    end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed self-checking bench for reg_wb_ctrl at DEPTH=2.
`timescale 1ns/1ps

module tb_reg_wb_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [2:0] id_rn_sel;
    logic       id_uses_r0;
    logic       id_uses_rn;
    logic       id_wr_r0;
    logic       id_wr_rn;
    logic [2:0] id_src;
    logic       flush;
    logic       id_stall;
    logic [1:0] ra_ctrl;
    logic [2:0] ra_s8;
    logic [2:0] ra_rn_sel;
    logic       busy;
    logic [7:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    reg_wb_ctrl #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rn_sel  (id_rn_sel),
        .id_uses_r0 (id_uses_r0),
        .id_uses_rn (id_uses_rn),
        .id_wr_r0   (id_wr_r0),
        .id_wr_rn   (id_wr_rn),
        .id_src     (id_src),
        .flush      (flush),
        .id_stall   (id_stall),
        .ra_ctrl    (ra_ctrl),
        .ra_s8      (ra_s8),
        .ra_rn_sel  (ra_rn_sel),
        .busy       (busy),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] sel, input logic ur0,
                                 input logic urn, input logic wr0, input logic wrn,
                                 input logic [2:0] src, input logic fl);
        id_valid   = v;
        id_rn_sel  = sel;
        id_uses_r0 = ur0;
        id_uses_rn = urn;
        id_wr_r0   = wr0;
        id_wr_rn   = wrn;
        id_src     = src;
        flush      = fl;
    endtask

    task automatic endCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 3'd6, 0, 0, 0, 0, 3'd0, 0);
        #2;
        checkOutput("rst ctrl", ra_ctrl, 0);
        checkOutput("rst s8", ra_s8, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst cnt", stall_cnt, 0);
        checkOutput("rst rnsel", ra_rn_sel, 6);
        @(negedge clk);
        rst_n = 1'b1;
        endCycle();

        // Test 1: single RN write travels to WB in cycle 3
        $display("[TB] test 1: basic write");
        applyStimulus(1, 3'd3, 0, 0, 0, 1, 3'b001, 0);
        @(negedge clk);
        checkOutput("t1 c0 ctrl", ra_ctrl, 0);
        checkOutput("t1 c0 busy", busy, 0);
        checkOutput("t1 c0 stall", id_stall, 0);
        endCycle();
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(0, 3'd0, 0, 0, 0, 0, 3'd0, 0);
            @(negedge clk);
            checkOutput($sformatf("t1 c%0d ctrl", c), ra_ctrl, (c == 3) ? 2 : 0);
            checkOutput($sformatf("t1 c%0d busy", c), busy, (c <= 3) ? 1 : 0);
            if (c == 3) begin
                checkOutput("t1 c3 s8", ra_s8, 3'b001);
                checkOutput("t1 c3 rnsel", ra_rn_sel, 3);
            end
            endCycle();
        end

        // Test 2: RAW on R3
        $display("[TB] test 2: RAW stall");
        applyStimulus(1, 3'd3, 0, 0, 0, 1, 3'b001, 0);
        @(negedge clk);
        checkOutput("t2 c0 stall", id_stall, 0);
        endCycle();
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(1, 3'd3, 0, 1, 0, 0, 3'd0, 0);
            @(negedge clk);
            checkOutput($sformatf("t2 c%0d stall", c), id_stall, (c <= 3) ? 1 : 0);
            if (c == 4)
                checkOutput("t2 cnt", stall_cnt, 3);
            endCycle();
        end

        // Test 3: RN selector conflict with WB
        $display("[TB] test 3: structural stall");
        applyStimulus(1, 3'd5, 0, 0, 0, 1, 3'b001, 0);
        endCycle();
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(1, 3'd2, 0, 1, 0, 0, 3'd0, 0);
            @(negedge clk);
            checkOutput($sformatf("t3 c%0d stall", c), id_stall, (c == 3) ? 1 : 0);
            checkOutput($sformatf("t3 c%0d rnsel", c), ra_rn_sel, (c == 3) ? 5 : 2);
            if (c == 4)
                checkOutput("t3 cnt", stall_cnt, 4);
            endCycle();
        end

        // Test 4: broadcast write blocks every read
        $display("[TB] test 4: broadcast");
        applyStimulus(1, 3'd4, 0, 0, 1, 1, 3'b100, 0);
        endCycle();
        applyStimulus(1, 3'd0, 1, 0, 0, 0, 3'd0, 0);
        @(negedge clk);
        checkOutput("t4 c1 stall", id_stall, 1);
        endCycle();
        applyStimulus(1, 3'd7, 0, 1, 0, 0, 3'd0, 0);
        @(negedge clk);
        checkOutput("t4 c2 stall", id_stall, 1);
        endCycle();
        applyStimulus(1, 3'd1, 0, 1, 0, 0, 3'd0, 0);
        @(negedge clk);
        checkOutput("t4 c3 stall", id_stall, 1);
        checkOutput("t4 c3 ctrl", ra_ctrl, 3);
        checkOutput("t4 c3 s8", ra_s8, 3'b100);
        checkOutput("t4 c3 rnsel", ra_rn_sel, 4);
        endCycle();
        applyStimulus(1, 3'd0, 1, 0, 0, 0, 3'd0, 0);
        @(negedge clk);
        checkOutput("t4 c4 stall", id_stall, 0);
        checkOutput("t4 c4 ctrl", ra_ctrl, 0);
        checkOutput("t4 c4 cnt", stall_cnt, 7);
        endCycle();

        // Test 5: flush kills the in-flight write and a same-cycle request
        $display("[TB] test 5: flush");
        applyStimulus(1, 3'd6, 0, 0, 0, 1, 3'b001, 0);
        endCycle();
        applyStimulus(1, 3'd0, 0, 0, 1, 0, 3'b011, 1);
        @(negedge clk);
        checkOutput("t5 c1 busy", busy, 1);
        checkOutput("t5 c1 stall", id_stall, 0);
        endCycle();
        for (int c = 2; c <= 5; c++) begin
            if (c == 2)
                applyStimulus(1, 3'd6, 0, 1, 0, 0, 3'd0, 0);
            else
                applyStimulus(1, 3'd0, 1, 0, 0, 0, 3'd0, 0);
            @(negedge clk);
            checkOutput($sformatf("t5 c%0d busy", c), busy, 0);
            checkOutput($sformatf("t5 c%0d ctrl", c), ra_ctrl, 0);
            checkOutput($sformatf("t5 c%0d stall", c), id_stall, 0);
            endCycle();
        end
        checkOutput("t5 cnt", stall_cnt, 7);

        // Test 6: asynchronous reset while a write sits in WB
        $display("[TB] test 6: reset mid-operation");
        applyStimulus(1, 3'd3, 0, 0, 0, 1, 3'b001, 0);
        endCycle();
        applyStimulus(0, 3'd5, 0, 0, 0, 0, 3'd0, 0);
        endCycle();
        endCycle();
        checkOutput("t6 pre ctrl", ra_ctrl, 2);
        checkOutput("t6 pre rnsel", ra_rn_sel, 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6 rst ctrl", ra_ctrl, 0);
        checkOutput("t6 rst busy", busy, 0);
        checkOutput("t6 rst cnt", stall_cnt, 0);
        checkOutput("t6 rst rnsel", ra_rn_sel, 5);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        endCycle();
        applyStimulus(1, 3'd2, 0, 0, 1, 0, 3'b101, 0);
        endCycle();
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(0, 3'd6, 0, 0, 0, 0, 3'd0, 0);
            @(negedge clk);
            checkOutput($sformatf("t6 c%0d ctrl", c), ra_ctrl, (c == 3) ? 1 : 0);
            checkOutput($sformatf("t6 c%0d busy", c), busy, (c <= 3) ? 1 : 0);
            if (c == 3) begin
                checkOutput("t6 c3 s8", ra_s8, 3'b101);
                checkOutput("t6 c3 rnsel", ra_rn_sel, 6);
            end
            endCycle();
        end

        // Test 7: stall counter saturation (3 stalls per round)
        $display("[TB] test 7: stall counter saturation");
        for (int r = 0; r < 90; r++) begin
            applyStimulus(1, 3'd1, 0, 0, 0, 1, 3'b001, 0);
            endCycle();
            for (int k = 0; k < 3; k++) begin
                applyStimulus(1, 3'd1, 0, 1, 0, 0, 3'd0, 0);
                endCycle();
            end
            if (r == 83)
                checkOutput("t7 cnt 252", stall_cnt, 252);
        end
        checkOutput("t7 cnt sat", stall_cnt, 255);
        applyStimulus(0, 3'd0, 0, 0, 0, 0, 3'd0, 0);
        endCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
